// File: rtl/csi2tx_lml_pkg.sv
// Shared types and constants for the CSI-2 TX lane management layer.
// Imported by the LDL lane scheduler and its helpers.
package csi2tx_lml_pkg;

   localparam int NUM_LAYERS = 8;
   localparam int LANE_CNT_W = 3;

   typedef enum logic [2:0] {
      ST_INIT    = 3'd0,
      ST_IDLE    = 3'd1,
      ST_ARM     = 3'd2,
      ST_ACTIVE  = 3'd3,
      ST_HS_EXIT = 3'd4
   } lml_state_e;

   function automatic logic [NUM_LAYERS-1:0] onehot_lane(
      input logic [LANE_CNT_W-1:0] sel
   );
      logic [NUM_LAYERS-1:0] oh;
      oh      = '0;
      oh[sel] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/csi2tx_ldl_down_counter.sv
// Loadable down counter that saturates at zero.
// Priority: reset > clear > load > decrement.
module csi2tx_ldl_down_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         decr,
   output logic [W-1:0] cnt,
   output logic         zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (decr && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == '0);

endmodule

// File: rtl/csi2tx_ldl_lane_scheduler.sv
// Sequences TINIT, then enables one LDL instance per packet and
// runs the HS-exit countdown that the selected layer waits on.
module csi2tx_ldl_lane_scheduler
   import csi2tx_lml_pkg::*;
#(
   parameter int NUM_LAYERS = csi2tx_lml_pkg::NUM_LAYERS,
   parameter int TINIT_W    = 16,
   parameter int HS_EXIT_W  = 8,
   parameter int PKT_CNT_W  = 16
) (
   input  logic                  txbyteclkhs,
   input  logic                  txbyteclkhs_rst,
   input  logic [2:0]            cfg_lane_cnt,
   input  logic [TINIT_W-1:0]    cfg_tinit_cnt,
   input  logic [HS_EXIT_W-1:0]  cfg_hs_exit_cnt,
   input  logic                  csi_byte_fifo_empty,
   input  logic                  forcetxstopmode,
   input  logic [NUM_LAYERS-1:0] ldl_tx_done,
   input  logic [NUM_LAYERS-1:0] ldl_hs_exit_decr,
   output logic                  tinit_start,
   output logic [NUM_LAYERS-1:0] lane_en,
   output logic                  enable_hs_transmission,
   output logic                  hs_exit_cnt_expired,
   output logic                  busy,
   output logic [PKT_CNT_W-1:0]  pkt_cnt,
   output logic                  cfg_chg_err
);

   localparam logic [2:0] LANE_SEL_MAX = 3'(NUM_LAYERS - 1);

   lml_state_e              state_q, state_d;
   logic [TINIT_W-1:0]      tinit_cnt_q, tinit_cnt_d;
   logic                    tinit_start_q, tinit_start_d;
   logic [2:0]              lane_sel_q, lane_sel_d;
   logic [NUM_LAYERS-1:0]   lane_en_q, lane_en_d;
   logic                    busy_q, busy_d;
   logic [PKT_CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
   logic                    cfg_chg_err_q, cfg_chg_err_d;

   logic [2:0]              sel_clamp;
   logic                    tinit_last;
   logic                    in_pkt;
   logic                    hx_load;
   logic                    hx_clr;
   logic                    hx_decr;
   logic                    hx_zero;
   logic [HS_EXIT_W-1:0]    hx_cnt;

   if (NUM_LAYERS < 8) begin : g_clamp
      assign sel_clamp = (cfg_lane_cnt > LANE_SEL_MAX) ?
                         LANE_SEL_MAX : cfg_lane_cnt;
   end else begin : g_full
      assign sel_clamp = cfg_lane_cnt;
   end

   // A zero TINIT config still spends one cycle in INIT.
   assign tinit_last = (cfg_tinit_cnt == '0) ||
                       (tinit_cnt_q == cfg_tinit_cnt - TINIT_W'(1));

   assign in_pkt = (state_q == ST_ARM) ||
                   (state_q == ST_ACTIVE) ||
                   (state_q == ST_HS_EXIT);

   assign hx_decr = (state_q == ST_HS_EXIT) &&
                    ldl_hs_exit_decr[lane_sel_q];

   always_comb begin
      state_d       = state_q;
      tinit_cnt_d   = tinit_cnt_q;
      tinit_start_d = tinit_start_q;
      lane_sel_d    = lane_sel_q;
      lane_en_d     = lane_en_q;
      pkt_cnt_d     = pkt_cnt_q;
      hx_load       = 1'b0;
      hx_clr        = 1'b0;
      cfg_chg_err_d = cfg_chg_err_q |
                      (busy_q && (sel_clamp != lane_sel_q));

      unique case (state_q)
         ST_INIT: begin
            tinit_cnt_d = tinit_cnt_q + TINIT_W'(1);
            if (tinit_last) begin
               state_d       = ST_IDLE;
               tinit_start_d = 1'b1;
            end
         end
         ST_IDLE: begin
            if (!csi_byte_fifo_empty) begin
               state_d    = ST_ARM;
               lane_sel_d = sel_clamp;
               lane_en_d  = onehot_lane(sel_clamp);
            end
         end
         ST_ARM: begin
            state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (ldl_tx_done[lane_sel_q]) begin
               state_d   = ST_HS_EXIT;
               hx_load   = 1'b1;
               pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
            end
         end
         ST_HS_EXIT: begin
            if (hx_zero) begin
               state_d   = ST_IDLE;
               lane_en_d = '0;
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase

      // Stop-mode abort overrides any transition decided above.
      if (forcetxstopmode && in_pkt) begin
         state_d   = ST_IDLE;
         lane_en_d = '0;
         pkt_cnt_d = pkt_cnt_q;
         hx_load   = 1'b0;
         hx_clr    = 1'b1;
      end

      busy_d = (state_d == ST_ACTIVE) || (state_d == ST_HS_EXIT);
   end

   always_ff @(posedge txbyteclkhs) begin
      if (txbyteclkhs_rst) begin
         state_q       <= ST_INIT;
         tinit_cnt_q   <= '0;
         tinit_start_q <= 1'b0;
         lane_sel_q    <= '0;
         lane_en_q     <= '0;
         busy_q        <= 1'b0;
         pkt_cnt_q     <= '0;
         cfg_chg_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         tinit_cnt_q   <= tinit_cnt_d;
         tinit_start_q <= tinit_start_d;
         lane_sel_q    <= lane_sel_d;
         lane_en_q     <= lane_en_d;
         busy_q        <= busy_d;
         pkt_cnt_q     <= pkt_cnt_d;
         cfg_chg_err_q <= cfg_chg_err_d;
      end
   end

   csi2tx_ldl_down_counter #(
      .W (HS_EXIT_W)
   ) u_hs_exit_cnt (
      .clk      (txbyteclkhs),
      .rst      (txbyteclkhs_rst),
      .clr      (hx_clr),
      .load     (hx_load),
      .load_val (cfg_hs_exit_cnt),
      .decr     (hx_decr),
      .cnt      (hx_cnt),
      .zero     (hx_zero)
   );

   assign tinit_start            = tinit_start_q;
   assign lane_en                = lane_en_q;
   assign busy                   = busy_q;
   assign pkt_cnt                = pkt_cnt_q;
   assign cfg_chg_err            = cfg_chg_err_q;
   assign enable_hs_transmission = (state_q == ST_ACTIVE);
   assign hs_exit_cnt_expired    = (state_q == ST_HS_EXIT) &&
                                   (hx_cnt == '0);

endmodule

// File: tb/tb_csi2tx_ldl_lane_scheduler.sv
// Scoreboard bench: packet drivers queue expected start/end records,
// a negedge monitor pops them as lane_en rises and falls.
module tb_csi2tx_ldl_lane_scheduler;

   logic        clk;
   logic        rst;
   logic [2:0]  cfg_lane_cnt;
   logic [15:0] cfg_tinit_cnt;
   logic [7:0]  cfg_hs_exit_cnt;
   logic        fifo_empty;
   logic        force_stop;
   logic [7:0]  tx_done;
   logic [7:0]  hx_decr;
   logic        tinit_start;
   logic [7:0]  lane_en;
   logic        en_hs;
   logic        expired;
   logic        busy;
   logic [3:0]  pkt_cnt;
   logic        chg_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] en;
      int         gap;
   } start_t;

   typedef struct {
      int         len;
      int         hs;
      int         expd;
      logic [3:0] pkt;
      logic       err;
   } end_t;

   start_t start_q[$];
   end_t   end_q[$];

   csi2tx_ldl_lane_scheduler #(
      .NUM_LAYERS (8),
      .TINIT_W    (16),
      .HS_EXIT_W  (8),
      .PKT_CNT_W  (4)
   ) dut (
      .txbyteclkhs            (clk),
      .txbyteclkhs_rst        (rst),
      .cfg_lane_cnt           (cfg_lane_cnt),
      .cfg_tinit_cnt          (cfg_tinit_cnt),
      .cfg_hs_exit_cnt        (cfg_hs_exit_cnt),
      .csi_byte_fifo_empty    (fifo_empty),
      .forcetxstopmode        (force_stop),
      .ldl_tx_done            (tx_done),
      .ldl_hs_exit_decr       (hx_decr),
      .tinit_start            (tinit_start),
      .lane_en                (lane_en),
      .enable_hs_transmission (en_hs),
      .hs_exit_cnt_expired    (expired),
      .busy                   (busy),
      .pkt_cnt                (pkt_cnt),
      .cfg_chg_err            (chg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act,
                      input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_pkt(input logic [7:0] en, input int gap,
                             input int len, input int hs,
                             input int expd, input logic [3:0] pkt,
                             input logic err);
      start_t s;
      end_t   e;
      s.en   = en;
      s.gap  = gap;
      e.len  = len;
      e.hs   = hs;
      e.expd = expd;
      e.pkt  = pkt;
      e.err  = err;
      start_q.push_back(s);
      end_q.push_back(e);
   endtask

   // dmode: 0 no decrement, 1 toggle 1/0, 2 every cycle.
   task automatic run_pkt(input logic [2:0] lane, input int k,
                          input logic [7:0] hsx, input int dmode,
                          input int force_at, input int chg_at,
                          input logic [2:0] chg_val, input bit keep);
      int         n;
      logic [7:0] sel;
      logic [7:0] nz;
      sel             = 8'h01 << lane;
      nz              = (lane == 3'd0) ? 8'h02 : 8'h01;
      cfg_lane_cnt    = lane;
      cfg_hs_exit_cnt = hsx;
      fifo_empty      = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (lane_en == 8'h00 && n < 20);
      if (lane_en == 8'h00) begin
         chk("arm_timeout", n, 1);
         return;
      end
      if (!keep) fifo_empty = 1'b1;
      tick();
      tx_done = nz;
      if (force_at >= 0) begin
         repeat (force_at) tick();
         force_stop = 1'b1;
         tick();
         force_stop = 1'b0;
      end else begin
         for (int i = 0; i < k; i++) begin
            if (i == chg_at) cfg_lane_cnt = chg_val;
            tick();
         end
         tx_done = nz | sel;
         tick();
         tx_done = nz;
      end
      n = 0;
      while (lane_en != 8'h00 && n < 100) begin
         hx_decr = nz;
         if (dmode == 2 || (dmode == 1 && n % 2 == 0))
            hx_decr = nz | sel;
         tick();
         n++;
      end
      hx_decr = 8'h00;
      tx_done = 8'h00;
      if (lane_en != 8'h00) chk("hs_exit_timeout", n, 0);
   endtask

   logic [7:0] prev_en, first_en;
   int cur_len, hs_len, bsy_len, exp_cyc, zero_run;
   bit held, exp_last, idle_bad;

   always @(negedge clk) begin
      start_t s;
      end_t   e;
      if (rst) begin
         prev_en  = 8'h00;
         zero_run = 0;
         idle_bad = 1'b0;
      end else if (lane_en != 8'h00) begin
         if (prev_en == 8'h00) begin
            if (start_q.size() == 0) begin
               chk("unexpected_start", lane_en, 0);
            end else begin
               s = start_q.pop_front();
               chk("start_lane_en", lane_en, s.en);
               if (s.gap >= 0) chk("gap_zero_cycles", zero_run, s.gap);
               chk("arm_no_hs", en_hs, 0);
               chk("idle_clean", idle_bad, 0);
            end
            cur_len  = 0;
            hs_len   = 0;
            bsy_len  = 0;
            exp_cyc  = 0;
            held     = 1'b1;
            first_en = lane_en;
         end
         cur_len++;
         if (en_hs) hs_len++;
         if (busy) bsy_len++;
         if (expired) exp_cyc++;
         exp_last = expired;
         if (lane_en != first_en || !$onehot(lane_en)) held = 1'b0;
      end else begin
         if (prev_en != 8'h00) begin
            if (end_q.size() == 0) begin
               chk("unexpected_end", cur_len, 0);
            end else begin
               e = end_q.pop_front();
               chk("pkt_len", cur_len, e.len);
               chk("hs_cycles", hs_len, e.hs);
               chk("busy_cycles", bsy_len, e.len - 1);
               chk("lane_en_held", held, 1);
               chk("expired_last", exp_last, e.expd);
               chk("expired_cycles", exp_cyc, e.expd);
               chk("pkt_cnt", pkt_cnt, e.pkt);
               chk("cfg_chg_err", chg_err, e.err);
            end
            zero_run = 0;
            idle_bad = 1'b0;
         end
         zero_run++;
         if (en_hs || busy || expired) idle_bad = 1'b1;
      end
      prev_en = lane_en;
   end

   initial begin
      int n;
      rst             = 1'b1;
      cfg_lane_cnt    = 3'd0;
      cfg_tinit_cnt   = 16'd10;
      cfg_hs_exit_cnt = 8'd0;
      fifo_empty      = 1'b1;
      force_stop      = 1'b0;
      tx_done         = 8'h00;
      hx_decr         = 8'h00;
      repeat (3) tick();
      chk("rst_tinit_start", tinit_start, 0);
      chk("rst_lane_en", lane_en, 0);
      chk("rst_enable_hs", en_hs, 0);
      chk("rst_expired", expired, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pkt_cnt", pkt_cnt, 0);
      chk("rst_cfg_chg_err", chg_err, 0);

      rst = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!tinit_start && n < 50);
      chk("tinit_cycles", n, 10);
      chk("tinit_lane_en", lane_en, 0);

      // lane 4, 21 ACTIVE cycles, HS-exit 5 with toggled decrement
      expect_pkt(8'h10, -1, 32, 21, 1, 4'd1, 1'b0);
      run_pkt(3'd4, 20, 8'd5, 1, -1, -1, 3'd0, 1'b0);
      // abort after 4 ACTIVE cycles
      expect_pkt(8'h10, 1, 5, 4, 0, 4'd1, 1'b0);
      run_pkt(3'd4, 0, 8'd5, 2, 3, -1, 3'd0, 1'b0);
      // lane count changes 4->2 mid-packet
      expect_pkt(8'h10, 1, 8, 6, 1, 4'd2, 1'b1);
      run_pkt(3'd4, 5, 8'd0, 0, -1, 2, 3'd2, 1'b0);
      expect_pkt(8'h04, 1, 3, 1, 1, 4'd3, 1'b1);
      run_pkt(3'd2, 0, 8'd0, 0, -1, -1, 3'd0, 1'b0);
      expect_pkt(8'h80, 1, 6, 2, 1, 4'd4, 1'b1);
      run_pkt(3'd7, 1, 8'd2, 2, -1, -1, 3'd0, 1'b0);
      // back-to-back minimum packets through the counter wrap
      for (int i = 0; i < 12; i++) begin
         expect_pkt(8'h01, 1, 3, 1, 1, 4'((5 + i) % 16), 1'b1);
         run_pkt(3'd0, 0, 8'd0, 0, -1, -1, 3'd0, i != 11);
      end

      repeat (4) tick();
      chk("start_q_drained", start_q.size(), 0);
      chk("end_q_drained", end_q.size(), 0);
      chk("tinit_start_sticky", tinit_start, 1);
      chk("final_lane_en", lane_en, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/csi2tx_ldl_lane_scheduler.md
Name: csi2tx_ldl_lane_scheduler

Overview:
Sequencing controller for the lane distribution layers (1- to 8-lane LDL instances) in the CSI-2 TX lane management layer. Runs the post-reset TINIT wait, then latches the configured lane count and one-hot enables exactly one LDL instance per packet. Gates HS transmission while the selected layer sends the packet, and owns the HS-exit countdown that the layer waits on. Sits between the register block / byte FIFO and the eight LDL instances.

Parameters:
NUM_LAYERS, 8, number of LDL instances (lane counts 1..NUM_LAYERS)
TINIT_W, 16, width of TINIT counter/config
HS_EXIT_W, 8, width of HS-exit counter/config
PKT_CNT_W, 16, width of packet counter

Ports:
txbyteclkhs  input  1  byte clock, sole clock
txbyteclkhs_rst  input  1  reset, synchronous, active-high
cfg_lane_cnt  input  3  active lanes minus one (0=1 lane .. 7=8 lanes)
cfg_tinit_cnt  input  TINIT_W  TINIT duration in byte clocks
cfg_hs_exit_cnt  input  HS_EXIT_W  HS-exit duration in byte clocks
csi_byte_fifo_empty  input  1  byte FIFO empty
forcetxstopmode  input  1  abort to stop state
ldl_tx_done  input  NUM_LAYERS  per-layer tx_done (level, STOP_STATE)
ldl_hs_exit_decr  input  NUM_LAYERS  per-layer hs_exit_cnt_decr_enable
tinit_start  output  1  TINIT complete, DPHY may be requested
lane_en  output  NUM_LAYERS  one-hot layer enable (five_lane_en etc.)
enable_hs_transmission  output  1  packet may start in selected layer
hs_exit_cnt_expired  output  1  HS-exit time elapsed
busy  output  1  packet in progress
pkt_cnt  output  PKT_CNT_W  completed packets, wraps
cfg_chg_err  output  1  sticky: cfg_lane_cnt changed while busy

Behaviour:
- Reset (sync, txbyteclkhs_rst=1): state INIT, tinit counter=0, lane_sel=0, hs-exit counter=0, pkt_cnt=0, cfg_chg_err=0; all outputs 0.
- Everything is registered. Exception: hs_exit_cnt_expired and enable_hs_transmission are decodes of registered state/counter; no input-to-output comb path.
- INIT: tinit counter increments each cycle. When counter == cfg_tinit_cnt-1 -> IDLE, tinit_start=1 from the next cycle and stays 1 until reset. cfg_tinit_cnt=0 treated as 1 (one INIT cycle).
- IDLE: when csi_byte_fifo_empty=0 -> ARM; latch lane_sel=cfg_lane_cnt on this transition.
- ARM (1 cycle): lane_en=onehot(lane_sel) asserted from ARM onward -> ACTIVE.
- ACTIVE: enable_hs_transmission=1, busy=1. When ldl_tx_done[lane_sel]=1 -> HS_EXIT; load hs-exit counter=cfg_hs_exit_cnt; pkt_cnt+1 (wraps at 2^PKT_CNT_W). ldl_tx_done of non-selected layers ignored.
- HS_EXIT: enable_hs_transmission=0, lane_en held, busy=1. Counter decrements by 1 on cycles where ldl_hs_exit_decr[lane_sel]=1 and counter != 0; saturates at 0.
- hs_exit_cnt_expired=1 iff state==HS_EXIT and counter==0. cfg_hs_exit_cnt=0 -> expired on first HS_EXIT cycle.
- Next cycle after expired=1 -> IDLE; lane_en drops to 0 on IDLE entry. Minimum packet-to-packet gap is IDLE+ARM = 2 cycles.
- lane_en is 0 in INIT and IDLE. Its one-hot property is guaranteed.
- forcetxstopmode=1 in ARM/ACTIVE/HS_EXIT -> IDLE next cycle; counter cleared, pkt_cnt not incremented, lane_en=0. Ignored in INIT and IDLE.
- Priority when events coincide: reset > forcetxstopmode > state transition.
- cfg_chg_err: set when busy=1 and cfg_lane_cnt != lane_sel. Cleared only by reset. A change takes effect only at the next IDLE->ARM latch.
- cfg_lane_cnt >= NUM_LAYERS: clamp lane_sel to NUM_LAYERS-1.

Decomposition:
- Shared package csi2tx_lml_pkg: state encodings (INIT, IDLE, ARM, ACTIVE, HS_EXIT), NUM_LAYERS, lane-count encoding constants, onehot decode function.
- One sub-module csi2tx_ldl_down_counter: load/decrement/saturate, zero flag. Used for HS-exit; the TINIT counter is inline.

Test Plan:
- Reset then cfg_tinit_cnt=10 -> tinit_start rises exactly 10 cycles after reset release; lane_en=0 throughout.
- cfg_lane_cnt=4, FIFO non-empty, ldl_tx_done[4] pulsed after 20 cycles -> lane_en=8'h10 from ARM; enable_hs high in ACTIVE only; pkt_cnt=1.
- cfg_hs_exit_cnt=5, ldl_hs_exit_decr[sel] toggling 1/0 -> expired after 5 decrement cycles (~10 clocks); IDLE next cycle; decr on non-selected bit has no effect.
- forcetxstopmode mid-ACTIVE -> IDLE next cycle, lane_en=0, pkt_cnt unchanged; new packet restarts via ARM.
- Change cfg_lane_cnt 4->2 during ACTIVE -> cfg_chg_err=1 sticky, lane_en stays 8'h10; next packet uses 8'h04.
- pkt_cnt at 16'hFFFF plus one packet -> wraps to 0; cfg_hs_exit_cnt=0 -> expired on first HS_EXIT cycle.
